// File: rtl/iddmm_host_drv.sv
// iddmm_host_drv
//   Host-side initiator for the IDDMM Montgomery multiplier engine.
//   Streams operand words into the engine x/y/m RAMs, requests a task,
//   buffers the N returned result words and replays them downstream.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, ld_mask[2:0]      job start (idle only); operands to load x/y/m
//   busy, done, err_proto    status; done pulses after last output beat
//   in_valid/in_ready/in_data      upstream operand stream
//   out_valid/out_ready/out_data/out_last  downstream result stream
//   wr_ena[2:0], wr_addr, wr_x/wr_y/wr_m   engine RAM write port
//   task_req/task_grant      engine request handshake
//   task_end, task_res       engine result beats (no backpressure)
module iddmm_host_drv #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        ld_mask,
  output logic              busy,
  output logic              done,
  output logic              err_proto,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K-1:0]      out_data,
  output logic              out_last,
  output logic [2:0]        wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [K-1:0]      wr_x,
  output logic [K-1:0]      wr_y,
  output logic [K-1:0]      wr_m,
  output logic              task_req,
  input  logic              task_grant,
  input  logic              task_end,
  input  logic [K-1:0]      task_res
);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, COLLECT, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  state_t            state, state_d;
  logic [2:0]        mask;
  logic [2:0]        op;
  logic [ADDR_W-1:0] idx, cnt, rd;
  logic              in_hs, grant_hs, capture, out_hs;
  logic              done_q, err_q;
  logic [2:0]        wr_ena_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [K-1:0]      wr_word_p1;
  logic [K-1:0]      res_buf [N];

  // Lowest selected operand (one-hot x/y/m).
  function automatic logic [2:0] first_op(input logic [2:0] m);
    if (m[0])      return 3'b001;
    else if (m[1]) return 3'b010;
    else if (m[2]) return 3'b100;
    else           return 3'b000;
  endfunction

  // Next selected operand above the current one, or 0 when loading is finished.
  function automatic logic [2:0] next_op(input logic [2:0] m, input logic [2:0] cur);
    case (cur)
      3'b001:  return m[1] ? 3'b010 : (m[2] ? 3'b100 : 3'b000);
      3'b010:  return m[2] ? 3'b100 : 3'b000;
      default: return 3'b000;
    endcase
  endfunction

  // task_req waits out the final RAM write pulse so the engine never
  // starts before its operands have landed.
  assign task_req  = (state == REQ) && (wr_ena_p1 == 3'b000);
  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && (rd == LAST);
  assign out_data  = (state == DRAIN) ? res_buf[rd] : '0;
  assign done      = done_q;
  assign err_proto = err_q;
  assign wr_ena    = wr_ena_p1;
  assign wr_addr   = wr_addr_p1;
  assign wr_x      = wr_word_p1;
  assign wr_y      = wr_word_p1;
  assign wr_m      = wr_word_p1;

  always_comb begin
    state_d  = state;
    in_hs    = (state == LOAD) && in_valid;
    grant_hs = task_req && task_grant;
    // A beat arriving together with the grant is result word 0.
    capture  = task_end && ((state == COLLECT) || grant_hs);
    out_hs   = (state == DRAIN) && out_ready;
    case (state)
      IDLE:    if (start) state_d = (ld_mask != 3'b000) ? LOAD : REQ;
      LOAD:    if (in_hs && (idx == LAST) && (next_op(mask, op) == 3'b000)) state_d = REQ;
      REQ:     if (grant_hs) state_d = (capture && (cnt == LAST)) ? DRAIN : COLLECT;
      COLLECT: if (capture && (cnt == LAST)) state_d = DRAIN;
      DRAIN:   if (out_hs && (rd == LAST)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered engine write port, one cycle after each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= '0;
      op         <= '0;
      idx        <= '0;
      cnt        <= '0;
      rd         <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ena_p1  <= '0;
      wr_addr_p1 <= '0;
      wr_word_p1 <= '0;
    end else begin
      state     <= state_d;
      done_q    <= out_hs && (rd == LAST);
      // Beats outside the collect window are dropped and flagged.
      err_q     <= err_q | (task_end && !capture);
      wr_ena_p1 <= in_hs ? op : 3'b000;
      if (in_hs) begin
        wr_addr_p1 <= idx;
        wr_word_p1 <= in_data;
        if (idx == LAST) begin
          idx <= '0;
          op  <= next_op(mask, op);
        end else begin
          idx <= idx + ADDR_W'(1);
        end
      end
      if ((state == IDLE) && start) begin
        mask <= ld_mask;
        op   <= first_op(ld_mask);
        idx  <= '0;
        cnt  <= '0;
        rd   <= '0;
      end
      if (capture) cnt <= (cnt == LAST) ? '0 : cnt + ADDR_W'(1);
      if (out_hs)  rd  <= (rd == LAST) ? '0 : rd + ADDR_W'(1);
    end
  end

  // Result buffer: one write port (engine), one read port (downstream).
  always_ff @(posedge clk) begin
    if (capture) res_buf[cnt] <= task_res;
  end

endmodule

// File: tb/tb_iddmm_host_drv.sv
module tb_iddmm_host_drv;
  localparam int K = 16;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready, task_grant, task_end;
  logic [2:0]    ld_mask;
  logic [K-1:0]  in_data, task_res;
  logic          busy, done, err_proto, in_ready, out_valid, out_last, task_req;
  logic [K-1:0]  out_data, wr_x, wr_y, wr_m;
  logic [2:0]    wr_ena;
  logic [1:0]    wr_addr;

  int nvec = 0;
  int nerr = 0;
  logic mon_en = 1'b0;
  logic hs_q = 1'b0;
  int q_ena[$];
  int q_addr[$];
  int q_data[$];

  iddmm_host_drv #(.K(K), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .ld_mask(ld_mask),
    .busy(busy), .done(done), .err_proto(err_proto),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m),
    .task_req(task_req), .task_grant(task_grant), .task_end(task_end), .task_res(task_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Handshake seen at this edge must produce a write pulse in the next cycle.
  always @(posedge clk) hs_q <= in_valid && in_ready && !rst;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("wr_timing", 32'(wr_ena != 3'b000), 32'(hs_q));
      if (wr_ena != 3'b000) begin
        chk("req_during_wr", 32'(task_req), 0);
        chk("wr_y_eq_x", 32'(wr_y), 32'(wr_x));
        chk("wr_m_eq_x", 32'(wr_m), 32'(wr_x));
        q_ena.push_back(int'(wr_ena));
        q_addr.push_back(int'(wr_addr));
        q_data.push_back(int'(wr_x));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_log();
    q_ena.delete();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic start_job(input logic [2:0] m);
    start = 1'b1;
    ld_mask = m;
    tick();
    start = 1'b0;
    ld_mask = 3'b000;
  endtask

  task automatic feed(input logic [K-1:0] d);
    int n = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!task_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(task_req), 1);
  endtask

  task automatic grant(input logic [K-1:0] base, input int gdly, input bit with_end);
    wait_req();
    repeat (gdly) tick();
    chk("req_held", 32'(task_req), 1);
    task_grant = 1'b1;
    if (with_end) begin
      task_end = 1'b1;
      task_res = base;
    end
    tick();
    task_grant = 1'b0;
    task_end = 1'b0;
    chk("req_drop", 32'(task_req), 0);
  endtask

  task automatic results(input logic [K-1:0] base, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      repeat (gap) tick();
      task_end = 1'b1;
      task_res = base + K'(i);
      tick();
      task_end = 1'b0;
      task_res = '0;
    end
  endtask

  task automatic drain(input logic [K-1:0] base, input logic [15:0] pat, input int plen);
    int idx = 0;
    int cyc = 0;
    logic stall = 1'b0;
    logic [K-1:0] prev = '0;
    while (idx < N && cyc < 40) begin
      out_ready = (cyc < plen) ? pat[cyc] : 1'b1;
      chk("out_valid", 32'(out_valid), 1);
      chk("done_early", 32'(done), 0);
      if (stall) chk("stall_stable", 32'(out_data), 32'(prev));
      if (out_valid && out_ready) begin
        chk("out_data", 32'(out_data), 32'(base + K'(idx)));
        chk("out_last", 32'(out_last), 32'(idx == N - 1));
        idx++;
        stall = 1'b0;
      end else begin
        stall = out_valid;
        prev = out_data;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_cnt", 32'(idx), 32'(N));
    chk("done_pulse", 32'(done), 1);
    chk("valid_after", 32'(out_valid), 0);
    chk("busy_after", 32'(busy), 0);
    tick();
    chk("done_once", 32'(done), 0);
  endtask

  // Loads x=1..4, y=0x11..0x14, m=0x101..0x104 back-to-back.
  task automatic full_load();
    logic [K-1:0] bases [3];
    bases[0] = 16'h0000;
    bases[1] = 16'h0010;
    bases[2] = 16'h0100;
    clear_log();
    start_job(3'b111);
    for (int o = 0; o < 3; o++)
      for (int i = 0; i < N; i++) feed(bases[o] + K'(i + 1));
    in_valid = 1'b0;
    chk("ready_drop", 32'(in_ready), 0);
    wait_req();
    chk("wr_count", 32'(q_ena.size()), 12);
    for (int j = 0; j < q_ena.size() && j < 12; j++) begin
      chk("wr_ena", 32'(q_ena[j]), 32'(1 << (j / N)));
      chk("wr_addr", 32'(q_addr[j]), 32'(j % N));
      chk("wr_data", 32'(q_data[j]), 32'(bases[j / N] + K'(j % N + 1)));
    end
  endtask

  initial begin
    int acc;
    rst = 1'b1; start = 1'b0; ld_mask = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; task_grant = 1'b0; task_end = 1'b0; task_res = '0;
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_task_req", 32'(task_req), 0);
    chk("rst_wr_ena", 32'(wr_ena), 0);
    chk("rst_wr_x", 32'(wr_x), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_proto), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);

    // Full load, grant after 5 cycles, consecutive results.
    full_load();
    grant(16'h00A0, 5, 1'b0);
    results(16'h00A0, 0, 3, 0);
    drain(16'h00A0, 16'hFFFF, 16);
    chk("err_clean", 32'(err_proto), 0);

    // Partial load with in_valid held high.
    clear_log();
    start_job(3'b010);
    acc = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1;
      in_data = 16'h0021 + K'(acc);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("part_accepted", 32'(acc), 4);
    chk("part_ready", 32'(in_ready), 0);
    wait_req();
    chk("part_wr_count", 32'(q_ena.size()), 4);
    for (int j = 0; j < q_ena.size() && j < 4; j++) begin
      chk("part_wr_ena", 32'(q_ena[j]), 32'h2);
      chk("part_wr_addr", 32'(q_addr[j]), 32'(j));
      chk("part_wr_data", 32'(q_data[j]), 32'(16'h0021 + j));
    end
    grant(16'h0050, 1, 1'b0);
    results(16'h0050, 0, 3, 1);
    drain(16'h0050, 16'hFFFF, 16);

    // No load; grant coincides with result word 0.
    clear_log();
    start_job(3'b000);
    chk("noload_req", 32'(task_req), 1);
    grant(16'h00C0, 0, 1'b1);
    results(16'h00C0, 1, 3, 0);
    chk("noload_wr", 32'(q_ena.size()), 0);
    drain(16'h00C0, 16'hFFFF, 16);

    // Result gaps and downstream stalls 1,0,0,1,0,1,1.
    start_job(3'b000);
    grant(16'h0070, 2, 1'b0);
    results(16'h0070, 0, 3, 2);
    drain(16'h0070, 16'h0069, 7);

    // Reset mid-collect, then a full job.
    start_job(3'b000);
    grant(16'h00E0, 1, 1'b0);
    results(16'h00E0, 0, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req", 32'(task_req), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    full_load();
    grant(16'h00B0, 3, 1'b0);
    results(16'h00B0, 0, 3, 0);
    drain(16'h00B0, 16'hFFFF, 16);

    // Stray task_end in IDLE, start ignored during COLLECT.
    task_end = 1'b1;
    task_res = 16'hDEAD;
    tick();
    task_end = 1'b0;
    task_res = '0;
    chk("err_set", 32'(err_proto), 1);
    chk("err_no_valid", 32'(out_valid), 0);
    chk("err_idle", 32'(busy), 0);
    start_job(3'b000);
    grant(16'h0090, 1, 1'b0);
    results(16'h0090, 0, 1, 0);
    start_job(3'b111);
    chk("late_start_ready", 32'(in_ready), 0);
    chk("late_start_busy", 32'(busy), 1);
    results(16'h0090, 2, 3, 0);
    drain(16'h0090, 16'hFFFF, 16);
    chk("late_start_idle", 32'(in_ready), 0);
    chk("err_sticky", 32'(err_proto), 1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iddmm_host_drv.md
Name: iddmm_host_drv

Overview:
Host-side initiator for the IDDMM Montgomery multiplier engine. It accepts operand words from an upstream valid/ready stream, writes them into the engine's x/y/m operand RAMs over the engine write port, and raises a task request. It then collects the N result words the engine returns, buffers them, and replays them on a downstream valid/ready stream. It sits between the Paillier exponentiation sequencer and the multiplier top.

Parameters:
K, 128, bits per word; must equal the engine K.
N, 32, words per operand/result; must equal the engine N.
ADDR_W, $clog2(N), word address width.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  job start pulse; accepted only while idle
ld_mask  in  3  operands to load, sampled with start; bit0=x, bit1=y, bit2=m
busy  out  1  high whenever the block is not idle
done  out  1  one-cycle pulse after the last result word is accepted downstream
err_proto  out  1  sticky; task_end was seen outside COLLECT
in_valid  in  1  upstream operand word valid
in_ready  out  1  operand word accepted when in_valid and in_ready are both high
in_data  in  K  operand word
out_valid  out  1  result word valid
out_ready  in  1  downstream ready
out_data  out  K  result word
out_last  out  1  marks word N-1 of the result
wr_ena  out  3  engine RAM write enables, one-hot; bit0=x, bit1=y, bit2=m
wr_addr  out  ADDR_W  engine RAM word address
wr_x, wr_y, wr_m  out  K each  engine write data; all three carry the same registered word
task_req  out  1  request to the engine
task_grant  in  1  engine accepts the request
task_end  in  1  task_res holds a valid result word this cycle
task_res  in  K  result word from the engine

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0. A reset mid-job returns to IDLE at the next edge and drops task_req, wr_ena, in_ready and out_valid. Operand RAMs and the result buffer are not cleared.
- States: IDLE, LOAD, REQ, COLLECT, DRAIN.
- IDLE
  - start=1 with ld_mask!=0 goes to LOAD. start=1 with ld_mask=0 goes to REQ and reuses the previous RAM contents.
  - start is ignored in every state except IDLE.
- LOAD
  - in_ready=1. Accepted words go in this order: x words 0..N-1 if mask bit0, then y words 0..N-1 if mask bit1, then m words 0..N-1 if mask bit2. Word 0 is the least-significant word.
  - Write latency is 1 cycle: the cycle after a handshake, wr_ena is one-hot for the current operand, wr_addr is the word index, and wr_x/wr_y/wr_m carry the word.
  - wr_ena is 0 in every cycle without a preceding handshake. in_valid gaps are allowed.
  - After the final selected word is accepted: in_ready goes to 0 the next cycle, and the state goes to REQ.
- REQ
  - task_req asserts no earlier than the cycle after the final wr_ena pulse.
  - task_req is held until task_grant=1 is sampled, then deasserts at the next edge and the state goes to COLLECT.
  - If task_end=1 in the same cycle as the grant, that word is captured as result word 0.
  - task_grant outside REQ is ignored.
- COLLECT
  - Each cycle with task_end=1 writes task_res into buffer[cnt] and increments cnt. Gaps are allowed.
  - The engine has no backpressure, so every beat is accepted.
  - After word N-1 is captured, the state goes to DRAIN.
- DRAIN
  - out_valid=1 and out_data=buffer[rd]. out_last=1 when rd==N-1.
  - out_data and out_last stay stable while out_ready=0. rd advances on each handshake.
  - On the last handshake: next state IDLE, out_valid=0, and done pulses for 1 cycle.
- err_proto is set by task_end=1 in IDLE, LOAD, REQ (before the grant) or DRAIN. Those words are discarded. err_proto is cleared only by rst.
- busy=1 in LOAD, REQ, COLLECT and DRAIN.
- The result buffer is an N x K register file or inferred RAM with one write port and one read port. out_data must be valid in the same cycle out_valid is high.

Test Plan:
(bench uses K=16, N=4)
1. Full load: start with ld_mask=111; feed x 0x0001..0x0004, y 0x0011..0x0014, m 0x0101..0x0104 back-to-back.
   -> 12 write pulses: wr_ena=001 addr 0..3 data 1..4, then 010, then 100, each 1 cycle after its handshake.
   -> task_req rises after the last pulse; grant after 5 cycles; task_res 0x00A0..0x00A3 on consecutive task_end.
   -> out_data 0x00A0..0x00A3 with out_last on the 4th word, then done pulses once.
2. Partial load: ld_mask=010 with in_valid held high.
   -> exactly 4 words accepted, only wr_ena=010 pulses, and in_ready=0 after the 4th handshake.
3. No load: ld_mask=000.
   -> task_req=1 the cycle after start, with no wr_ena activity.
4. Stalls: task_end with 2-cycle gaps; out_ready pattern 1,0,0,1,0,1,1.
   -> all 4 words delivered in order, out_data stable during stalls, done only after the 4th handshake.
5. Reset mid-job: rst after 2 results captured.
   -> next cycle task_req=0, busy=0, out_valid=0; a following full job completes correctly.
6. Protocol error: task_end=1 in IDLE, and start pulsed while in COLLECT.
   -> err_proto=1 and stays 1; out_valid stays 0; the second start has no effect.
